// File: rtl/pop_best_select_pkg.sv
// Shared parameters, FSM encoding and bus helpers for the population
// best/second-best selector and its upstream distance stage.
package gbr_pkg;
    localparam int N_IND  = 50;
    localparam int DIST_W = 12;
    localparam int IDX_W  = 6;
    localparam int SUM_W  = 18;

    typedef enum logic [1:0] {IDLE, SCAN, FINISH} state_t;

    function automatic logic [DIST_W-1:0] dist_at(
        input logic [N_IND*DIST_W-1:0] bus,
        input logic [IDX_W-1:0]        i
    );
        return bus[int'(i)*DIST_W +: DIST_W];
    endfunction
endpackage

// File: rtl/pop_best_select_if.sv
// Start/result bus between the GA controller (master) and the selector (slave).
interface pop_best_select_if;
    import gbr_pkg::*;

    logic                    start;
    logic [N_IND*DIST_W-1:0] distances;
    logic                    busy;
    logic                    done;
    logic [IDX_W-1:0]        best_idx;
    logic [DIST_W-1:0]       best_dist;
    logic [IDX_W-1:0]        second_idx;
    logic [DIST_W-1:0]       second_dist;
    logic [SUM_W-1:0]        total_dist;

    modport master (
        output start, distances,
        input  busy, done, best_idx, best_dist, second_idx, second_dist, total_dist
    );

    modport slave (
        input  start, distances,
        output busy, done, best_idx, best_dist, second_idx, second_dist, total_dist
    );
endinterface

// File: rtl/pop_best_select_best2_update.sv
// Combinational best/second-best update for one new (distance, index) entry.
// Strict compares keep the lowest index among equal distances.
module best2_update
    import gbr_pkg::*;
(
    input  logic [DIST_W-1:0] i_best_dist,
    input  logic [IDX_W-1:0]  i_best_idx,
    input  logic              i_best_vld,
    input  logic [DIST_W-1:0] i_sec_dist,
    input  logic [IDX_W-1:0]  i_sec_idx,
    input  logic              i_sec_vld,
    input  logic [DIST_W-1:0] i_d,
    input  logic [IDX_W-1:0]  i_i,
    output logic [DIST_W-1:0] o_best_dist,
    output logic [IDX_W-1:0]  o_best_idx,
    output logic              o_best_vld,
    output logic [DIST_W-1:0] o_sec_dist,
    output logic [IDX_W-1:0]  o_sec_idx,
    output logic              o_sec_vld
);
    always_comb begin
        o_best_dist = i_best_dist;
        o_best_idx  = i_best_idx;
        o_best_vld  = i_best_vld;
        o_sec_dist  = i_sec_dist;
        o_sec_idx   = i_sec_idx;
        o_sec_vld   = i_sec_vld;
        if (!i_best_vld) begin
            o_best_dist = i_d;
            o_best_idx  = i_i;
            o_best_vld  = 1'b1;
        end else if (i_d < i_best_dist) begin
            // old best is demoted, never lost
            o_sec_dist  = i_best_dist;
            o_sec_idx   = i_best_idx;
            o_sec_vld   = 1'b1;
            o_best_dist = i_d;
            o_best_idx  = i_i;
        end else if (!i_sec_vld || (i_d < i_sec_dist)) begin
            o_sec_dist  = i_d;
            o_sec_idx   = i_i;
            o_sec_vld   = 1'b1;
        end
    end
endmodule

// File: rtl/pop_best_select.sv
// Scans a snapshot of the population distances one entry per cycle, picking
// the two fittest individuals (crossover parents) and the population total.
module pop_best_select
    import gbr_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    pop_best_select_if.slave   bus
);
    if (N_IND < 2) begin : g_chk_n
        $error("pop_best_select: N_IND must be >= 2");
    end
    if (SUM_W < DIST_W + IDX_W) begin : g_chk_sum
        $error("pop_best_select: SUM_W too narrow for the population total");
    end

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_IND - 1);

    state_t                  r_state;
    logic [N_IND*DIST_W-1:0] r_snap;
    logic [IDX_W-1:0]        r_idx;
    logic [SUM_W-1:0]        r_sum;
    logic                    r_busy;
    logic                    r_done;

    // working pair, only meaningful while scanning
    logic [DIST_W-1:0]       r_wb_dist, r_ws_dist;
    logic [IDX_W-1:0]        r_wb_idx,  r_ws_idx;
    logic                    r_wb_vld,  r_ws_vld;

    // published results, held until the next FINISH
    logic [DIST_W-1:0]       r_best_dist, r_sec_dist;
    logic [IDX_W-1:0]        r_best_idx,  r_sec_idx;
    logic [SUM_W-1:0]        r_total;

    logic [DIST_W-1:0]       w_d;
    logic [DIST_W-1:0]       w_nb_dist, w_ns_dist;
    logic [IDX_W-1:0]        w_nb_idx,  w_ns_idx;
    logic                    w_nb_vld,  w_ns_vld;

    assign w_d = dist_at(r_snap, r_idx);

    best2_update u_best2 (
        .i_best_dist (r_wb_dist),
        .i_best_idx  (r_wb_idx),
        .i_best_vld  (r_wb_vld),
        .i_sec_dist  (r_ws_dist),
        .i_sec_idx   (r_ws_idx),
        .i_sec_vld   (r_ws_vld),
        .i_d         (w_d),
        .i_i         (r_idx),
        .o_best_dist (w_nb_dist),
        .o_best_idx  (w_nb_idx),
        .o_best_vld  (w_nb_vld),
        .o_sec_dist  (w_ns_dist),
        .o_sec_idx   (w_ns_idx),
        .o_sec_vld   (w_ns_vld)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_snap      <= '0;
            r_idx       <= '0;
            r_sum       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_wb_dist   <= '0;
            r_wb_idx    <= '0;
            r_wb_vld    <= 1'b0;
            r_ws_dist   <= '0;
            r_ws_idx    <= '0;
            r_ws_vld    <= 1'b0;
            r_best_dist <= '0;
            r_best_idx  <= '0;
            r_sec_dist  <= '0;
            r_sec_idx   <= '0;
            r_total     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_snap   <= bus.distances;
                        r_wb_vld <= 1'b0;
                        r_ws_vld <= 1'b0;
                        r_sum    <= '0;
                        r_idx    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= SCAN;
                    end
                end
                SCAN: begin
                    r_wb_dist <= w_nb_dist;
                    r_wb_idx  <= w_nb_idx;
                    r_wb_vld  <= w_nb_vld;
                    r_ws_dist <= w_ns_dist;
                    r_ws_idx  <= w_ns_idx;
                    r_ws_vld  <= w_ns_vld;
                    r_sum     <= r_sum + SUM_W'(w_d);
                    if (r_idx == LAST_IDX) r_state <= FINISH;
                    else                   r_idx   <= r_idx + IDX_W'(1);
                end
                FINISH: begin
                    r_best_dist <= r_wb_dist;
                    r_best_idx  <= r_wb_idx;
                    r_sec_dist  <= r_ws_dist;
                    r_sec_idx   <= r_ws_idx;
                    r_total     <= r_sum;
                    r_done      <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.best_idx    = r_best_idx;
    assign bus.best_dist   = r_best_dist;
    assign bus.second_idx  = r_sec_idx;
    assign bus.second_dist = r_sec_dist;
    assign bus.total_dist  = r_total;
endmodule

// File: tb/tb_pop_best_select.sv
// Directed bench for pop_best_select with a cycle-level reference model.
module tb_pop_best_select;
    import gbr_pkg::*;

    localparam int BW = N_IND*DIST_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pop_best_select_if bus();
    pop_best_select dut (.clk(clk), .rst(rst), .bus(bus));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: order statistics over the whole vector, lowest index first on ties.
    task automatic ref_select(input logic [BW-1:0] v, output int bi, output int bd,
                              output int si, output int sd, output int tot);
        int d [N_IND];
        for (int i = 0; i < N_IND; i++) d[i] = int'(v[i*DIST_W +: DIST_W]);
        bi = 0; tot = 0;
        for (int i = 0; i < N_IND; i++) begin
            tot += d[i];
            if (d[i] < d[bi]) bi = i;
        end
        si = (bi == 0) ? 1 : 0;
        for (int i = 0; i < N_IND; i++)
            if (i != bi && d[i] < d[si]) si = i;
        bd = d[bi]; sd = d[si];
    endtask

    // Model: a run is just "N_IND+1 busy edges, then publish"; no FSM mirroring.
    bit             m_live = 0;
    bit             m_done = 0;
    int             m_cnt  = 0;
    logic [BW-1:0]  m_snap;
    int m_bi = 0, m_bd = 0, m_si = 0, m_sd = 0, m_tot = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_live = 1; m_cnt = 0; m_done = 0;
            m_bi = 0; m_bd = 0; m_si = 0; m_sd = 0; m_tot = 0;
        end else if (m_live) begin
            m_done = 0;
            if (m_cnt == 0) begin
                if (bus.start) begin
                    m_snap = bus.distances;
                    m_cnt  = N_IND + 1;
                end
            end else begin
                m_cnt--;
                if (m_cnt == 0) begin
                    ref_select(m_snap, m_bi, m_bd, m_si, m_sd, m_tot);
                    m_done = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("busy",        int'(bus.busy),        int'(m_cnt > 0));
            chk("done",        int'(bus.done),        int'(m_done));
            chk("best_idx",    int'(bus.best_idx),    m_bi);
            chk("best_dist",   int'(bus.best_dist),   m_bd);
            chk("second_idx",  int'(bus.second_idx),  m_si);
            chk("second_dist", int'(bus.second_dist), m_sd);
            chk("total_dist",  int'(bus.total_dist),  m_tot);
        end
    end

    task automatic chk_out(input string nm, input int bi, input int bd,
                           input int si, input int sd, input int tot);
        chk({nm, ".best_idx"},    int'(bus.best_idx),    bi);
        chk({nm, ".best_dist"},   int'(bus.best_dist),   bd);
        chk({nm, ".second_idx"},  int'(bus.second_idx),  si);
        chk({nm, ".second_dist"}, int'(bus.second_dist), sd);
        chk({nm, ".total_dist"},  int'(bus.total_dist),  tot);
    endtask

    // Caller sits at a negedge; returns negedges until done (N_IND+2 nominal).
    task automatic wait_done(output int n);
        n = 1;
        while (!bus.done && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.done) chk("done_timeout", 0, 1);
    endtask

    task automatic run(input logic [BW-1:0] v, output int lat);
        bus.distances = v;
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(lat);
    endtask

    logic [BW-1:0] v1, v2, v3, vz;
    int lat, bi, bd, si, sd, tot, ndone;

    initial begin
        for (int i = 0; i < N_IND; i++) begin
            v1[i*DIST_W +: DIST_W] = DIST_W'(1000 - 10*i);
            v2[i*DIST_W +: DIST_W] = DIST_W'(4095);
            v3[i*DIST_W +: DIST_W] = (i == 3 || i == 7) ? DIST_W'(5) : DIST_W'(900);
        end
        vz = '0;

        // pin the model against hand-computed values
        ref_select(v1, bi, bd, si, sd, tot);
        chk("model_v1_bi", bi, 49);  chk("model_v1_si", si, 48);
        chk("model_v1_tot", tot, 37750);
        ref_select(v3, bi, bd, si, sd, tot);
        chk("model_v3_bi", bi, 3);   chk("model_v3_si", si, 7);

        bus.start = 1'b0;
        bus.distances = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_busy", int'(bus.busy), 0);
        chk_out("reset", 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);

        // descending distances
        run(v1, lat);
        chk("latency", lat, N_IND + 2);
        chk("t1_busy_with_done", int'(bus.busy), 0);
        chk_out("t1", 49, 510, 48, 520, 37750);
        repeat (3) @(negedge clk);

        // saturated entries: all-equal tie break and max total
        run(v2, lat);
        chk_out("t2", 0, 4095, 1, 4095, 204750);
        @(negedge clk);

        // ties + second start and input change mid-scan
        bus.distances = v3;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (20) @(negedge clk);
        bus.start = 1'b1;
        bus.distances = vz;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(lat);
        chk("t3_latency", lat, N_IND + 2 - 21);
        chk_out("t3", 3, 5, 7, 5, 43210);
        // start during the done cycle is accepted
        bus.distances = v1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("t4_busy_after_done_start", int'(bus.busy), 1);
        wait_done(lat);
        chk_out("t4", 49, 510, 48, 520, 37750);
        @(negedge clk);

        // reset at scan index 25
        bus.distances = v2;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (25) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5_busy", int'(bus.busy), 0);
        chk_out("t5_reset", 0, 0, 0, 0, 0);
        ndone = 0;
        repeat (60) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        chk("t5_no_done", ndone, 0);
        run(v1, lat);
        chk("t5_latency", lat, N_IND + 2);
        chk_out("t5", 49, 510, 48, 520, 37750);

        // outputs hold without start
        bus.distances = v2;
        ndone = 0;
        repeat (200) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        chk("t6_no_done", ndone, 0);
        chk_out("t6_hold", 49, 510, 48, 520, 37750);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pop_best_select.md
Name: pop_best_select

Overview:
- Downstream stage of the population distance computer; consumes its 50 × 12-bit tour distances once that stage reports done.
- Sequentially scans the distances to find the two fittest individuals (smallest and second-smallest distance) and their indices. These are the parent indices for the crossover stage.
- Also accumulates the population total distance, used for convergence monitoring.
- One entry is processed per cycle; the input is snapshotted so the upstream stage may restart immediately.

Parameters:
- N_IND, 50, number of individuals in the population
- DIST_W, 12, width of one distance
- IDX_W, 6, width of an individual index (ceil log2 N_IND)
- SUM_W, 18, width of the population total (covers N_IND × (2^DIST_W − 1) = 204750)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; sampled only in IDLE; driven by the controller when upstream done is seen
- distances  in  N_IND*DIST_W  flattened distances; entry i occupies bits [i*DIST_W +: DIST_W]
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse; results are valid from this cycle on
- best_idx  out  IDX_W  index of the smallest distance
- best_dist  out  DIST_W  smallest distance
- second_idx  out  IDX_W  index of the second-smallest distance (always ≠ best_idx)
- second_dist  out  DIST_W  second-smallest distance
- total_dist  out  SUM_W  sum of all N_IND distances

Behaviour:
- Reset (synchronous, active-high; clock and reset are the only timing inputs): state=IDLE; busy=0; done=0; all result outputs=0; scan index=0; snapshot register cleared.
- FSM states: IDLE, SCAN, FINISH.
- IDLE:
  - start=1 at edge k: copy distances into the snapshot; clear the working best/second valid flags and the running sum; set the scan index to 0; go to SCAN.
  - busy=1 from cycle k+1.
- SCAN: one entry per cycle, processed at edges k+1 … k+N_IND, index 0 … N_IND−1. For entry d at index i:
  - best invalid: best ← (d, i).
  - Otherwise, d < best_dist (strict): second ← best; best ← (d, i).
  - Otherwise, second invalid or d < second_dist: second ← (d, i).
  - The sum adds d, zero-extended to SUM_W.
  - After i = N_IND−1, go to FINISH.
- Tie rule: strict compare, so the lowest index wins among equal distances. All-equal input gives best_idx=0, second_idx=1.
- FINISH (one cycle):
  - Copy the working registers to the output registers.
  - done=1 for exactly this one cycle; busy=0 in the same cycle; return to IDLE.
  - Total latency: start at edge k → done high in the cycle following edge k+N_IND+1.
- Outputs hold their values until the next FINISH; they do not change during a later SCAN.
- start while busy (SCAN or FINISH): ignored, with no queuing.
- start in the cycle done is high: the FSM is already in IDLE, so it is accepted. Back-to-back runs are allowed, one run every N_IND+2 cycles.
- Changes on distances after the start edge have no effect on the current run.
- Reset mid-scan: abort immediately; all outputs return to reset values; no done pulse.
- No overflow is possible in the sum by construction; SUM_W must be ≥ DIST_W + IDX_W.
- N_IND must be ≥ 2 (checked by an elaboration-time assertion).

Decomposition:
- Package gbr_pkg holds:
  - N_IND, DIST_W, IDX_W, SUM_W, shared with the distance stage.
  - The state enum {IDLE, SCAN, FINISH}.
  - A function returning the distance slice for index i from the flattened bus.
- One natural sub-module, best2_update: combinational. Inputs are the current best/second (dist, idx, valid) plus the new (d, i); output is the next best/second. It keeps the compare rules unit-testable. The FSM, counter, snapshot and sum stay in pop_best_select.

Test Plan:
- Distinct values, distances[i] = 1000 − 10·i → best_idx=49, best_dist=510, second_idx=48, second_dist=520, total_dist=37750; done exactly N_IND+2 cycles after start.
- All entries = 4095 → best_idx=0, second_idx=1, both dists 4095, total_dist=204750 (no overflow).
- Ties: entry 7 = 5, entry 3 = 5, all others 900 → best_idx=3, second_idx=7, best_dist=second_dist=5.
- Handshake: pulse start again at scan index 20, and change distances mid-scan → second start ignored; results match the snapshot; a single done pulse. Then start in the done cycle → accepted, busy next cycle.
- Reset at scan index 25 → outputs 0, busy=0, no done. A fresh start with the first test's vector → correct results.
- Outputs hold: after a run, drive new distances with no start for 200 cycles → outputs unchanged, done stays 0.
